fsm_controle_multi: RTL and testbench

- Parametrised successor of the single-channel motor controller.
- Drives N_CH independent motors from synchronised sensor inputs, each with temporal hysteresis (cooldown countdown), turn-on qualification delay and maximum-run watchdog fault.
- Adds a runtime-loadable cooldown time, a global enable, and a display mux selecting one channel's timer.
- Sits between the sensor synchronisers / 1 Hz tick generator and the motor drivers / 7-segment display path.

---
 rtl/fsm_controle_multi.sv | 156 +++++++++++++++
 tb/tb_fsm_controle_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_controle_multi.sv
// Multi-channel motor controller: per-channel start qualification, run
// watchdog and cooldown hysteresis, with a runtime cooldown time, a global
// enable and a display mux exposing one channel's timer.
module fsm_controle_multi #(
  parameter int N_CH         = 4,
  parameter int TIMER_W      = 5,
  parameter int COOLDOWN_DEF = 20,
  parameter int ON_DELAY     = 2,
  parameter int MAX_RUN      = 60,
  localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_1hz,
  input  logic [N_CH-1:0]      sensor_sync,
  input  logic                 enable,
  input  logic [TIMER_W-1:0]   cfg_cooldown,
  input  logic                 cfg_load,
  input  logic [N_CH-1:0]      fault_clr,
  input  logic [SEL_W-1:0]     disp_sel,
  output logic [N_CH-1:0]      motor_on,
  output logic [N_CH-1:0]      fault,
  output logic [TIMER_W-1:0]   timer_val,
  output logic [3*N_CH-1:0]    state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_RUN      = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  // Counters keep at least one bit so a disabled feature still elaborates.
  localparam int ARM_W = (ON_DELAY > 0) ? $clog2(ON_DELAY + 1) : 1;
  localparam int RUN_W = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;

  localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'((ON_DELAY > 0) ? ON_DELAY - 1 : 0);
  localparam logic [RUN_W-1:0]   RUN_LAST  = RUN_W'((MAX_RUN > 0) ? MAX_RUN - 1 : 0);
  localparam logic [RUN_W-1:0]   RUN_SAT   = {RUN_W{1'b1}};
  localparam logic [TIMER_W-1:0] COOL_INIT = TIMER_W'(COOLDOWN_DEF);

  state_t             st      [N_CH];
  logic [TIMER_W-1:0] timer   [N_CH];
  logic [ARM_W-1:0]   arm_cnt [N_CH];
  logic [RUN_W-1:0]   run_cnt [N_CH];
  logic [TIMER_W-1:0] cooldown_reg;

  // Per-channel state machines plus the shared cooldown register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cooldown_reg <= COOL_INIT;
      for (int i = 0; i < N_CH; i++) begin
        st[i]      <= ST_IDLE;
        timer[i]   <= '0;
        arm_cnt[i] <= '0;
        run_cnt[i] <= '0;
      end
    end else begin
      // A zero cooldown would make the motor stop without any hysteresis.
      if (cfg_load) begin
        cooldown_reg <= (cfg_cooldown == '0) ? TIMER_W'(1) : cfg_cooldown;
      end
      for (int i = 0; i < N_CH; i++) begin
        case (st[i])
          ST_IDLE: begin
            timer[i] <= '0;
            if (enable && sensor_sync[i]) begin
              arm_cnt[i] <= '0;
              run_cnt[i] <= '0;
              if (ON_DELAY == 0) begin
                st[i]    <= ST_RUN;
                timer[i] <= cooldown_reg;
              end else begin
                st[i] <= ST_ARM;
              end
            end
          end
          ST_ARM: begin
            timer[i] <= '0;
            if (!sensor_sync[i] || !enable) begin
              st[i] <= ST_IDLE;
            end else if (tick_1hz) begin
              if (arm_cnt[i] == ARM_LAST) begin
                st[i]      <= ST_RUN;
                run_cnt[i] <= '0;
                timer[i]   <= cooldown_reg;
              end else begin
                arm_cnt[i] <= arm_cnt[i] + ARM_W'(1);
              end
            end
          end
          ST_RUN: begin
            // Timer tracks cooldown_reg so COOLDOWN starts from the latest value.
            timer[i] <= cooldown_reg;
            if (tick_1hz && (run_cnt[i] != RUN_SAT)) begin
              run_cnt[i] <= run_cnt[i] + RUN_W'(1);
            end
            if ((MAX_RUN != 0) && tick_1hz && (run_cnt[i] == RUN_LAST)) begin
              st[i]    <= ST_FAULT;
              timer[i] <= '0;
            end else if (!sensor_sync[i] || !enable) begin
              st[i] <= ST_COOLDOWN;
            end
          end
          ST_COOLDOWN: begin
            if (sensor_sync[i] && enable) begin
              st[i]      <= ST_RUN;
              run_cnt[i] <= '0;
              timer[i]   <= cooldown_reg;
            end else if (timer[i] == '0) begin
              st[i] <= ST_IDLE;
            end else if (tick_1hz) begin
              timer[i] <= timer[i] - TIMER_W'(1);
            end
          end
          ST_FAULT: begin
            timer[i] <= '0;
            // Clearing with demand still present would restart straight into the fault.
            if (fault_clr[i] && !sensor_sync[i]) begin
              st[i] <= ST_IDLE;
            end
          end
          default: begin
            st[i]    <= ST_IDLE;
            timer[i] <= '0;
          end
        endcase
      end
    end
  end

  // Motor, fault and debug outputs decoded straight from the state registers.
  always_comb begin
    motor_on  = '0;
    fault     = '0;
    state_dbg = '0;
    for (int i = 0; i < N_CH; i++) begin
      motor_on[i]          = (st[i] == ST_RUN) || (st[i] == ST_COOLDOWN);
      fault[i]             = (st[i] == ST_FAULT);
      state_dbg[3*i +: 3]  = st[i];
    end
  end

  // Display mux; a selector with no matching channel shows zero.
  always_comb begin
    timer_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (disp_sel == SEL_W'(i)) begin
        timer_val = timer[i];
      end
    end
  end

endmodule

// File: tb/tb_fsm_controle_multi.sv
// Scoreboard bench for fsm_controle_multi (N_CH=4, defaults elsewhere).
module tb_fsm_controle_multi;

  localparam int IDLE = 0, ARM = 1, RUN = 2, COOL = 3, FLT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1hz = 1'b0;
  logic [3:0]  sensor_sync = 4'b1111;
  logic        enable = 1'b1;
  logic [4:0]  cfg_cooldown = 5'd0;
  logic        cfg_load = 1'b0;
  logic [3:0]  fault_clr = 4'b0000;
  logic [1:0]  disp_sel = 2'd0;
  logic [3:0]  motor_on;
  logic [3:0]  fault;
  logic [4:0]  timer_val;
  logic [11:0] state_dbg;

  fsm_controle_multi dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .sensor_sync(sensor_sync),
    .enable(enable), .cfg_cooldown(cfg_cooldown), .cfg_load(cfg_load),
    .fault_clr(fault_clr), .disp_sel(disp_sel), .motor_on(motor_on),
    .fault(fault), .timer_val(timer_val), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [11:0] sd;
    logic [3:0]  mo;
    logic [3:0]  fa;
    logic [4:0]  tv;
  } exp_t;

  exp_t q[$];
  int   es[4] = '{0, 0, 0, 0};
  int   et = 0;
  bit   done = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Expected outputs built from the hand-tracked channel states.
  task automatic push_exp(input string nm);
    exp_t e;
    e.name = nm; e.sd = '0; e.mo = '0; e.fa = '0;
    for (int i = 0; i < 4; i++) begin
      e.sd[3*i +: 3] = 3'(es[i]);
      e.mo[i] = (es[i] == RUN) || (es[i] == COOL);
      e.fa[i] = (es[i] == FLT);
    end
    e.tv = 5'(et);
    q.push_back(e);
  endtask

  task automatic clk1(input logic t);
    tick_1hz = t;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) clk1(1'b1);
  endtask

  // Monitor: compares every pending expectation against the settled outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (state_dbg !== e.sd || motor_on !== e.mo || fault !== e.fa || timer_val !== e.tv) begin
        errors++;
        $display("FAIL %s: got state=%h motor=%b fault=%b timer=%0d, want state=%h motor=%b fault=%b timer=%0d",
                 e.name, state_dbg, motor_on, fault, timer_val, e.sd, e.mo, e.fa, e.tv);
      end
    end
    if (done) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with all sensors demanding
    for (int k = 0; k < 5; k++) begin
      clk1(1'b1);
      push_exp("reset_hold");
    end
    checks++;
    if (motor_on !== 4'b0000 || timer_val !== 5'd0 || state_dbg !== 12'd0) begin
      errors++;
      $display("FAIL direct reset: motor=%b timer=%0d state=%h", motor_on, timer_val, state_dbg);
    end

    // Start qualification on ch0
    reset = 1'b1; sensor_sync = 4'b0001; disp_sel = 2'd0;
    clk1(1'b0); es[0] = ARM; push_exp("ch0_arm");
    clk1(1'b1); push_exp("ch0_arm_tick1");
    clk1(1'b0); clk1(1'b0); push_exp("ch0_arm_wait");
    clk1(1'b1); es[0] = RUN; et = 20; push_exp("ch0_run_after_2");
    checks++;
    if (motor_on[0] !== 1'b1 || timer_val !== 5'd20) begin
      errors++;
      $display("FAIL direct ch0 run: motor=%b timer=%0d", motor_on, timer_val);
    end

    // Cooldown with re-trigger at 7, then full countdown to IDLE
    sensor_sync = 4'b0000;
    clk1(1'b0); es[0] = COOL; push_exp("ch0_cool_20");
    clk1(1'b1); et = 19; push_exp("ch0_cool_19");
    ticks(12); et = 7; push_exp("ch0_cool_7");
    sensor_sync = 4'b0001;
    clk1(1'b0); es[0] = RUN; et = 20; push_exp("ch0_retrigger");
    sensor_sync = 4'b0000;
    clk1(1'b0); es[0] = COOL; push_exp("ch0_cool_again");
    ticks(20); et = 0; push_exp("ch0_cool_0");
    clk1(1'b0); es[0] = IDLE; push_exp("ch0_idle");

    // Short pulse never starts the motor
    sensor_sync = 4'b0001;
    clk1(1'b0); es[0] = ARM; push_exp("pulse_arm");
    clk1(1'b1); push_exp("pulse_tick");
    sensor_sync = 4'b0000;
    clk1(1'b0); es[0] = IDLE; push_exp("pulse_idle");

    // Runtime cooldown load does not disturb a countdown in progress
    disp_sel = 2'd1; sensor_sync = 4'b0010;
    clk1(1'b0); es[1] = ARM;
    ticks(2); es[1] = RUN; et = 20; push_exp("ch1_run");
    sensor_sync = 4'b0000;
    clk1(1'b0); es[1] = COOL;
    ticks(8); et = 12; push_exp("ch1_cool_12");
    cfg_cooldown = 5'd5; cfg_load = 1'b1;
    clk1(1'b0); cfg_load = 1'b0; push_exp("ch1_load_keeps_12");
    ticks(12); et = 0; push_exp("ch1_cool_0");
    clk1(1'b0); es[1] = IDLE; push_exp("ch1_idle");

    disp_sel = 2'd2; sensor_sync = 4'b0100;
    clk1(1'b0); es[2] = ARM;
    ticks(2); es[2] = RUN; et = 5; push_exp("ch2_run_cd5");
    sensor_sync = 4'b0000;
    clk1(1'b0); es[2] = COOL; push_exp("ch2_cool_5");
    ticks(5); et = 0; push_exp("ch2_cool_0");
    clk1(1'b0); es[2] = IDLE; push_exp("ch2_idle");

    cfg_cooldown = 5'd0; cfg_load = 1'b1;
    clk1(1'b0); cfg_load = 1'b0;
    sensor_sync = 4'b0100;
    clk1(1'b0); es[2] = ARM;
    ticks(2); es[2] = RUN; et = 1; push_exp("ch2_run_clamped");
    sensor_sync = 4'b0000;
    clk1(1'b0); es[2] = COOL; push_exp("ch2_cool_1");
    clk1(1'b1); et = 0; push_exp("ch2_cool_0b");
    clk1(1'b0); es[2] = IDLE; push_exp("ch2_idle_b");
    cfg_cooldown = 5'd20; cfg_load = 1'b1;
    clk1(1'b0); cfg_load = 1'b0;

    // Run watchdog on ch3 and fault clearing rules
    disp_sel = 2'd3; sensor_sync = 4'b1000;
    clk1(1'b0); es[3] = ARM;
    ticks(2); es[3] = RUN; et = 20;
    ticks(59); push_exp("ch3_run_59");
    clk1(1'b1); es[3] = FLT; et = 0; push_exp("ch3_fault");
    checks++;
    if (fault !== 4'b1000 || motor_on[3] !== 1'b0) begin
      errors++;
      $display("FAIL direct ch3 fault: fault=%b motor=%b", fault, motor_on);
    end
    fault_clr = 4'b1000;
    clk1(1'b0); push_exp("ch3_clr_ignored");
    fault_clr = 4'b0000; sensor_sync = 4'b0000;
    clk1(1'b0); push_exp("ch3_fault_holds");
    fault_clr = 4'b1000;
    clk1(1'b0); es[3] = IDLE; push_exp("ch3_cleared");
    checks++;
    if (fault !== 4'b0000) begin
      errors++;
      $display("FAIL direct ch3 cleared: fault=%b", fault);
    end
    fault_clr = 4'b0000;

    // Global enable drop with ch0 running and ch1 arming
    disp_sel = 2'd0; sensor_sync = 4'b0001;
    clk1(1'b0); es[0] = ARM;
    ticks(2); es[0] = RUN; et = 20;
    sensor_sync = 4'b0011;
    clk1(1'b0); es[1] = ARM; push_exp("en_ch1_arm");
    enable = 1'b0;
    clk1(1'b0); es[0] = COOL; es[1] = IDLE; push_exp("en_drop");
    clk1(1'b1); et = 19; push_exp("en_off_no_restart");
    enable = 1'b1;
    clk1(1'b0); es[0] = RUN; es[1] = ARM; et = 20; push_exp("en_restore");

    clk1(1'b0);
    done = 1'b1;
  end

endmodule
